// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - mode constants and rotating first-one helper shared by arb_mux_nx1
package arb_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_IN     = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] scanning upward from ptr+1, wrapping at n.
  function automatic rr_pick_t rr_first_one(input logic [MAX_IN-1:0] req,
                                            input logic [3:0] ptr, input int n);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = 0; k < MAX_IN; k++) begin
      idx = int'(ptr) + 1 + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !pick.valid && idx < MAX_IN) begin
        if (req[idx[3:0]]) begin
          pick.valid = 1'b1;
          pick.idx   = idx[3:0];
        end
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among NUM_IN requests
module rr_arbiter import arb_mux_pkg::*; #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [SEL_W-1:0]  grant_o,
  output logic              grant_valid_o
);
  rr_pick_t pick;

  always_comb pick = rr_first_one(MAX_IN'(req_i), 4'(ptr_i), NUM_IN);

  assign grant_o       = SEL_W'(pick.idx);
  assign grant_valid_o = pick.valid;
endmodule

// File: rtl/arb_mux_nx1.sv
// rtl/arb_mux_nx1.sv - NUM_IN:1 valid/ready merge with fixed-select or round-robin arbitration
// Optional ARB_MUX_PKT_LOCK_EN: in_last/out_last ports and packet-locked round-robin grants.
module arb_mux_nx1 import arb_mux_pkg::*; #(
  parameter int N      = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [NUM_IN-1:0]   in_valid,
  input  logic [NUM_IN*N-1:0] in_data,
`ifdef ARB_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]   in_last,
  output logic                out_last,
`endif
  output logic [NUM_IN-1:0]   in_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_data,
  output logic [SEL_W-1:0]    out_src,
  input  logic                out_ready
);
  localparam int SEL_SPAN = 1 << SEL_W;

  logic                out_valid_q, out_valid_d;
  logic [N-1:0]        out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_src_q, out_src_d;
  logic [SEL_W-1:0]    last_grant_q, last_grant_d;
  logic [SEL_SPAN-1:0] valid_ext;
  logic [SEL_W-1:0]    rr_grant, grant;
  logic                rr_grant_valid, grant_valid, load_en, xfer;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic                lock_q, lock_d, out_last_q, out_last_d;
`endif

  // Zero-extended so an out-of-range sel reads a 0 valid bit and never grants.
  assign valid_ext = SEL_SPAN'(in_valid);

  rr_arbiter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_rr_arbiter (
    .req_i         (in_valid),
    .ptr_i         (last_grant_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  always_comb begin
    grant       = sel;
    grant_valid = valid_ext[sel];
    if (mode != MODE_FIXED) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
`ifdef ARB_MUX_PKT_LOCK_EN
      // While locked, the last granted channel is the only candidate.
      if (lock_q) begin
        grant       = last_grant_q;
        grant_valid = in_valid[last_grant_q];
      end
`endif
    end
  end

  // rst_n gating keeps every in_ready low while the block is held in reset.
  assign load_en  = rst_n && (!out_valid_q || out_ready);
  assign xfer     = load_en && grant_valid;
  assign in_ready = xfer ? (NUM_IN'(1) << grant) : '0;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
`ifdef ARB_MUX_PKT_LOCK_EN
    lock_d       = lock_q;
    out_last_d   = out_last_q;
`endif
    if (load_en) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = in_data[int'(grant)*N +: N];
        out_src_d  = grant;
        if (mode == MODE_RR) last_grant_d = grant;
`ifdef ARB_MUX_PKT_LOCK_EN
        out_last_d = in_last[grant];
        if (mode == MODE_RR) lock_d = !in_last[grant];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q       <= 1'b0;
      out_last_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q       <= lock_d;
      out_last_q   <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
`ifdef ARB_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb/tb_arb_mux_nx1.sv - randomized self-checking bench for arb_mux_nx1 against a behavioural model
module tb_arb_mux_nx1;
  localparam int N      = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n, mode, out_ready, out_valid;
  logic [SEL_W-1:0]    sel, out_src;
  logic [NUM_IN-1:0]   in_valid, in_ready;
  logic [NUM_IN*N-1:0] in_data;
  logic [N-1:0]        out_data;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic [NUM_IN-1:0]   in_last;
  logic                out_last;
`endif

  always #5 clk = ~clk;

  arb_mux_nx1 #(.N(N), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
`ifdef ARB_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the output register contents and the round-robin pointer.
  bit           m_valid;
  logic [N-1:0] m_data;
  int           m_src;
  int           m_ptr;

  function automatic void model_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = NUM_IN - 1;
  endfunction

  function automatic logic [N-1:0] chan(input int i);
    return in_data[i*N +: N];
  endfunction

  function automatic void model_pick(output bit gv, output int g);
    gv = 0; g = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < NUM_IN && in_valid[sel]) begin gv = 1; g = int'(sel); end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        int c;
        c = (m_ptr + k) % NUM_IN;
        if (!gv && in_valid[c]) begin gv = 1; g = c; end
      end
    end
  endfunction

  function automatic logic [NUM_IN-1:0] model_ready();
    bit gv; int g;
    logic [NUM_IN-1:0] r;
    r = '0;
    model_pick(gv, g);
    if (rst_n && (!m_valid || out_ready) && gv) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void model_clock();
    bit gv; int g;
    if (!rst_n) begin model_reset(); return; end
    model_pick(gv, g);
    if (!m_valid || out_ready) begin
      m_valid = gv;
      if (gv) begin
        m_data = chan(g); m_src = g;
        if (mode) m_ptr = g;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < NUM_IN; i++) in_data[i*N +: N] = 32'hCAFE0000 + 32'(i);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
    set_pattern();
    model_reset();
    repeat (2) tick();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", in_ready); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd0) $display("FAIL reset_out_src got %0d want 0", out_src); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL reset_first_ready got %b want 0001", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hCAFE0000)
      $display("FAIL reset_first_grant got v=%b src=%0d data=%h want v=1 src=0 data=cafe0000", out_valid, out_src, out_data);
    else n_pass++;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL fixed_ready got %b want 0100", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_data !== 32'hCAFE0002 || out_src !== 2'd2)
      $display("FAIL fixed_out got src=%0d data=%h want src=2 data=cafe0002", out_src, out_data);
    else n_pass++;
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (out_src !== SEL_W'(k % NUM_IN) || out_data !== 32'hCAFE0000 + 32'(k % NUM_IN))
        $display("FAIL rr_fair beat %0d got src=%0d data=%h want src=%0d", k, out_src, out_data, k % NUM_IN);
      else n_pass++;
    end
  endtask

  task automatic test_rr_skip();
    apply_reset();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL rr_skip_setup got %b want 0010", in_ready); else n_pass++;
    tick();
    in_valid = 4'b1010;
    #1;
    n_checks++; if (in_ready !== 4'b1000) $display("FAIL rr_skip_ready3 got %b want 1000", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_src !== 2'd3) $display("FAIL rr_skip_src3 got %0d want 3", out_src); else n_pass++;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL rr_skip_ready1 got %b want 0010", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_src !== 2'd1) $display("FAIL rr_skip_src1 got %0d want 1", out_src); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held;
    apply_reset();
    set_pattern();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    tick();
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) in_data[i*N +: N] = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL bp_ready cyc %0d got %b want 0000", k, in_ready); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hCAFE0000)
        $display("FAIL bp_hold cyc %0d got v=%b src=%0d data=%h want v=1 src=0 data=%h", k, out_valid, out_src, out_data, held);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL bp_resume_ready got %b want 0010", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_src !== 2'd1 || out_data !== m_data)
      $display("FAIL bp_resume got src=%0d data=%h want src=1 data=%h", out_src, out_data, m_data);
    else n_pass++;
  endtask

  task automatic test_invalid_sel();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL badsel_ready got %b want 0000", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL badsel_drain got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_src !== SEL_W'(m_src) || out_data !== m_data)
      $display("FAIL badsel_hold got src=%0d data=%h want src=%0d data=%h", out_src, out_data, m_src, m_data);
    else n_pass++;
    tick();
    n_checks++; if (in_ready !== 4'b0000 || out_valid !== 1'b0)
      $display("FAIL badsel_idle got ready=%b v=%b want 0000 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = SEL_W'($urandom);
      in_valid  = NUM_IN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_IN; i++) in_data[i*N +: N] = $urandom;
      #1;
      n_checks++; if (in_ready !== model_ready())
        $display("FAIL rand_ready cyc %0d got %b want %b", k, in_ready, model_ready());
      else n_pass++;
      n_checks++; if (out_valid !== m_valid || out_src !== SEL_W'(m_src) || out_data !== m_data)
        $display("FAIL rand_out cyc %0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                 k, out_valid, out_src, out_data, m_valid, m_src, m_data);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    set_pattern();
    tick();
    apply_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0)
      $display("FAIL midreset got v=%b src=%0d data=%h want 0 0 0", out_valid, out_src, out_data);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd0)
      $display("FAIL midreset_first got v=%b src=%0d want v=1 src=0", out_valid, out_src);
    else n_pass++;
  endtask

`ifdef ARB_MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int exp_src[4] = '{1, 1, 1, 2};
    apply_reset();
    set_pattern();
    mode = 1'b1; in_valid = 4'b0110; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_last = (k == 2) ? 4'b1111 : 4'b1101;
      tick();
      n_checks++; if (out_src !== SEL_W'(exp_src[k]) || out_last !== (k >= 2))
        $display("FAIL pkt_lock beat %0d got src=%0d last=%b want src=%0d", k, out_src, out_last, exp_src[k]);
      else n_pass++;
    end
    in_last = '1;
  endtask
`endif

  initial begin
`ifdef ARB_MUX_PKT_LOCK_EN
    in_last = '1;
`endif
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_rr_skip();
    test_backpressure();
    test_invalid_sel();
    test_random();
    test_reset_mid();
`ifdef ARB_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
